// File: rtl/conv_window_buffer_pkg.sv
// Shared types and default geometry for the streaming KxK window generator.
// Optional stall counter output is enabled by defining WIN_STALL_CNT_EN.
package conv_window_buffer_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_K       = 3;
  localparam int unsigned DEF_IMG_W   = 28;
  localparam int unsigned DEF_IMG_H   = 28;
  localparam int unsigned STALL_CNT_W = 16;

  // Frame progress: filling the line buffers, emitting windows, last window pending.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LAST   = 2'd2
  } state_e;

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
interface conv_window_buffer_if
  import conv_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned K      = DEF_K
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [K*K*DATA_W-1:0] win_data;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, frame_done
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, frame_done
  );

endinterface

// File: rtl/conv_window_buffer_line_buffer_row.sv
// One image row of pixel storage; each shift writes the current column and
// pre-reads the next column so its output is ready for the following pixel.
module conv_window_buffer_line_buffer_row #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 28,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (shift_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (shift_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator (stride 1, no padding), raster-order input.
// Define WIN_STALL_CNT_EN to add the stall_cnt_o output-backpressure counter.
module conv_window_buffer
  import conv_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  conv_window_buffer_if.slave    bus
`ifdef WIN_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned WIN_W = K * K * DATA_W;
  localparam int unsigned NLB   = K - 1;

  state_e            state_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              win_valid_q, win_valid_d;
  logic [WIN_W-1:0]  win_data_q, win_data_d;
  logic              frame_done_q;
  logic [DATA_W-1:0] sr_q [K][K];
  logic [DATA_W-1:0] sr_d [K][K];
  logic [DATA_W-1:0] lb_rd [NLB];
  logic [DATA_W-1:0] lb_wr [NLB];
  logic [COL_W-1:0]  col_nxt_c;
  logic              in_ready_c, accept_c, emit_c, win_hs_c, col_last_c, row_last_c;

  assign in_ready_c = en_i && !rst_i && (!win_valid_q || bus.win_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign win_hs_c   = en_i && win_valid_q && bus.win_ready;
  assign col_last_c = (col_q == COL_W'(IMG_W - 1));
  assign row_last_c = (row_q == ROW_W'(IMG_H - 1));
  assign col_nxt_c  = col_last_c ? '0 : col_q + COL_W'(1);
  assign emit_c     = accept_c && (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

  // Row i feeds row i+1, so the deepest row holds the oldest image row.
  for (genvar i = 0; i < NLB; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = bus.in_data;
    end else begin : g_chain
      assign lb_wr[i] = lb_rd[i-1];
    end
    conv_window_buffer_line_buffer_row #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_row (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .shift_i   (accept_c),
      .wr_addr_i (col_q),
      .rd_addr_i (col_nxt_c),
      .wr_data_i (lb_wr[i]),
      .rd_data_o (lb_rd[i])
    );
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept_c) begin
      col_d = col_nxt_c;
      if (col_last_c) begin
        row_d = row_last_c ? '0 : row_q + ROW_W'(1);
      end
    end
  end

  // New column enters on the right: oldest row from the deepest line buffer, newest from the input.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        sr_d[r][c] = sr_q[r][c];
      end
    end
    if (accept_c) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        sr_d[r][K-1] = lb_rd[K-2-r];
      end
      sr_d[K-1][K-1] = bus.in_data;
    end
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    if (emit_c) begin
      win_valid_d = 1'b1;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_data_d[(r*K+c)*DATA_W +: DATA_W] = sr_d[r][c];
        end
      end
    end else if (win_hs_c) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    sr_q <= sr_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_FILL;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      frame_done_q <= (state_q == ST_LAST) && win_hs_c;
      case (state_q)
        ST_FILL: begin
          if (accept_c && col_last_c && (row_q == ROW_W'(K - 2))) begin
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (emit_c && row_last_c && col_last_c) begin
            state_q <= ST_LAST;
          end
        end
        ST_LAST: begin
          if (win_hs_c) begin
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

`ifdef WIN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Counts cycles a presented window waits on the consumer, per frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || frame_done_q) begin
      stall_cnt_q <= '0;
    end else if (en_i && win_valid_q && !bus.win_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer on a 5x4 image with a 3x3 window.
module tb_conv_window_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IMG_W  = 5;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned K      = 3;
  localparam int unsigned WIN_W  = K * K * DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  conv_window_buffer_if #(.DATA_W(DATA_W), .K(K)) bus ();
`ifdef WIN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  conv_window_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .bus   (bus)
`ifdef WIN_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference: frame image, pending window and its frame-end flag.
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  logic              m_valid = 1'b0;
  logic              m_last  = 1'b0;
  logic              m_fd    = 1'b0;
  logic [WIN_W-1:0]  m_data  = '0;
  int unsigned       m_n     = 0;
  int unsigned       acc_cnt = 0;
  logic              rand_mode = 1'b0;
  logic              hold_pend = 1'b0;
  logic [WIN_W-1:0]  hold_data = '0;
  int                fd_seen = 0;
  logic [WIN_W-1:0]  got_q [$];

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] build(input int r, input int c);
    logic [WIN_W-1:0] w = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        w[(rr*K+cc)*DATA_W +: DATA_W] = img[r-K+1+rr][c-K+1+cc];
    return w;
  endfunction

  // Window whose top-left pixel value is base, for images with pixel = row*IMG_W+col.
  function automatic logic [WIN_W-1:0] mkwin(input int base);
    logic [WIN_W-1:0] w = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        w[(rr*K+cc)*DATA_W +: DATA_W] = DATA_W'(base + rr*IMG_W + cc);
    return w;
  endfunction

  function automatic int win_base(input int i);
    return (i / (IMG_W-K+1)) * IMG_W + (i % (IMG_W-K+1));
  endfunction

  // One clock: drive at negedge, check after settle, advance reference at posedge.
  task automatic step(input logic v, input logic wr, input logic e);
    logic [DATA_W-1:0] d;
    logic exp_rdy, acc, hs;
    int r, c;
    d = rand_mode ? DATA_W'($urandom) : DATA_W'(m_n);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.win_ready = wr;
    en = e;
    #1;
    exp_rdy = e && !rst && (!m_valid || wr);
    chk("in_ready", WIN_W'(bus.in_ready), WIN_W'(exp_rdy));
    chk("win_valid", WIN_W'(bus.win_valid), WIN_W'(m_valid));
    if (m_valid) chk("win_data", bus.win_data, m_data);
    chk("frame_done", WIN_W'(bus.frame_done), WIN_W'(m_fd));
    if (hold_pend) begin
      chk("hold_valid", WIN_W'(bus.win_valid), WIN_W'(1));
      chk("hold_data", bus.win_data, hold_data);
    end
    acc = v && exp_rdy;
    hs  = m_valid && wr && e && !rst;
    if (bus.frame_done) fd_seen++;
    if (bus.win_valid && wr && e && !rst) got_q.push_back(bus.win_data);
    hold_pend = bus.win_valid && !(wr && e) && !rst;
    hold_data = bus.win_data;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_fd    = 1'b0;
      m_n     = 0;
    end else begin
      m_fd = hs && m_last;
      if (hs) m_valid = 1'b0;
      if (acc) begin
        acc_cnt++;
        r = int'(m_n / IMG_W);
        c = int'(m_n % IMG_W);
        img[r][c] = d;
        m_n = (m_n + 1) % (IMG_W * IMG_H);
        if (r >= K-1 && c >= K-1) begin
          m_valid = 1'b1;
          m_data  = build(r, c);
          m_last  = (r == IMG_H-1) && (c == IMG_W-1);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic stream(input int n);
    int start = int'(acc_cnt);
    for (int i = 0; i < 20*n + 50 && int'(acc_cnt) - start < n; i++) step(1'b1, 1'b1, 1'b1);
    chk("stream_accepts", WIN_W'(int'(acc_cnt) - start), WIN_W'(n));
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic clear_log();
    got_q.delete();
    fd_seen = 0;
  endtask

  initial begin
    int start, stall;
    logic sc_done, paused;
    rst = 1'b1;
    en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.win_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    chk("rst_win_data", bus.win_data, '0);

    // Test 1: plain frame
    clear_log();
    stream(20);
    drain();
    chk("t1_count", WIN_W'(got_q.size()), WIN_W'(6));
    chk("t1_first", (got_q.size() > 0) ? got_q[0] : '0, mkwin(0));
    chk("t1_last", (got_q.size() > 5) ? got_q[5] : '0, mkwin(7));
    chk("t1_frame_done", WIN_W'(fd_seen), WIN_W'(1));

    // Test 2: hold window 2 for five cycles
    clear_log();
    start = int'(acc_cnt);
    stall = 0;
    sc_done = 1'b0;
    for (int i = 0; i < 200 && int'(acc_cnt) - start < 20; i++) begin
      if (got_q.size() == 1 && m_valid && stall < 5) begin
        chk("t2_stall_data", bus.win_data, mkwin(1));
        step(1'b1, 1'b0, 1'b1);
        stall++;
      end else begin
        if (stall == 5 && !sc_done) begin
`ifdef WIN_STALL_CNT_EN
          chk("t2_stall_cnt", WIN_W'(stall_cnt), WIN_W'(5));
`endif
          sc_done = 1'b1;
        end
        step(1'b1, 1'b1, 1'b1);
      end
    end
    drain();
    chk("t2_stalled", WIN_W'(stall), WIN_W'(5));
    chk("t2_count", WIN_W'(got_q.size()), WIN_W'(6));
    for (int i = 0; i < 6; i++)
      chk("t2_seq", (i < got_q.size()) ? got_q[i] : '0, mkwin(win_base(i)));
    chk("t2_frame_done", WIN_W'(fd_seen), WIN_W'(1));

    // Test 3: enable low for four cycles mid-row 2, window pending
    clear_log();
    start = int'(acc_cnt);
    paused = 1'b0;
    for (int i = 0; i < 200 && int'(acc_cnt) - start < 20; i++) begin
      if (int'(acc_cnt) - start == 13 && !paused) begin
        repeat (4) step(1'b1, 1'b1, 1'b0);
        paused = 1'b1;
      end
      step(1'b1, 1'b1, 1'b1);
    end
    drain();
    chk("t3_count", WIN_W'(got_q.size()), WIN_W'(6));
    for (int i = 0; i < 6; i++)
      chk("t3_seq", (i < got_q.size()) ? got_q[i] : '0, mkwin(win_base(i)));

    // Test 4: reset after nine pixels, then a full frame
    stream(9);
    do_reset();
    clear_log();
    stream(20);
    drain();
    chk("t4_count", WIN_W'(got_q.size()), WIN_W'(6));
    chk("t4_first", (got_q.size() > 0) ? got_q[0] : '0, mkwin(0));
    chk("t4_frame_done", WIN_W'(fd_seen), WIN_W'(1));

    // Test 5: two back-to-back frames
    clear_log();
    stream(40);
    drain();
    chk("t5_count", WIN_W'(got_q.size()), WIN_W'(12));
    chk("t5_f2_first", (got_q.size() > 6) ? got_q[6] : '0, mkwin(0));
    chk("t5_f2_last", (got_q.size() > 11) ? got_q[11] : '0, mkwin(7));
    chk("t5_frame_done", WIN_W'(fd_seen), WIN_W'(2));

    // Test 6: random valid/ready with random pixel data, three frames
    clear_log();
    rand_mode = 1'b1;
    start = int'(acc_cnt);
    for (int i = 0; i < 2000 && int'(acc_cnt) - start < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drain();
    chk("t6_accepts", WIN_W'(int'(acc_cnt) - start), WIN_W'(60));
    chk("t6_count", WIN_W'(got_q.size()), WIN_W'(18));
    chk("t6_frame_done", WIN_W'(fd_seen), WIN_W'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
